// File: rtl/fifo_chk_pkg.sv
// fifo_chk_pkg: shared state type, default parameters and helpers for fifo_order_checker.
package fifo_chk_pkg;

  typedef enum logic [0:0] {
    CHK_CLEAN  = 1'b0,
    CHK_FAILED = 1'b1
  } chk_state_e;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_RD_LATENCY = 1;
  localparam int DEF_CNT_W      = 16;

  // Increment that sticks at max_val; counters up to 32 bits wide.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_chk_queue.sv
// fifo_chk_queue: shadow circular buffer holding the words the checked FIFO should contain.
module fifo_chk_queue
  import fifo_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop_req,
  output logic             push_ok,
  output logic             pop_ok,
  output logic             ovf,
  output logic             unf,
  output logic [WIDTH-1:0] head,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // A full queue still accepts a write when a legal pop frees a slot in the same cycle.
  assign pop_ok  = pop_req && (level != '0);
  assign push_ok = push_req && ((level != LVL_W'(DEPTH)) || pop_ok);
  assign ovf     = push_req && !push_ok;
  assign unf     = pop_req && (level == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fifo_order_checker.sv
// fifo_order_checker: passive scoreboard checking FIFO read order, overflow and underflow.
// Define FIFO_CHK_FLAG_CHECK_EN to also check the FIFO's full/empty flags against the model.
//
// state      | meaning
// CHK_CLEAN  | no mismatch seen since reset; first mismatch is captured
// CHK_FAILED | first mismatch captured; captures frozen until reset
module fifo_order_checker
  import fifo_chk_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           rd_data,
  input  logic                       dut_full,
  input  logic                       dut_empty,
  output logic                       err_order,
  output logic                       err_ovf,
  output logic                       err_unf,
  output logic                       err_flag,
  output logic                       err_sticky,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [CNT_W-1:0]           mismatch_cnt,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [WIDTH-1:0]           first_exp,
  output logic [WIDTH-1:0]           first_act
);

  localparam int          LVL_W   = $clog2(DEPTH + 1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic             push_ok;
  logic             pop_ok;
  logic             ovf;
  logic             unf;
  logic [WIDTH-1:0] head;
  logic             cmp_valid;
  logic [WIDTH-1:0] cmp_exp;
  logic             mismatch;
  logic             hit;
  logic             flag_err;
  chk_state_e       state;

  fifo_chk_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push_req (wr_en),
    .wr_data  (wr_data),
    .pop_req  (rd_en),
    .push_ok  (push_ok),
    .pop_ok   (pop_ok),
    .ovf      (ovf),
    .unf      (unf),
    .head     (head),
    .level    (level)
  );

  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign cmp_valid = pop_ok;
      assign cmp_exp   = head;
    end else begin : g_lat1
      // Head word travels with a pending bit to meet rd_data one cycle later.
      logic             pend;
      logic [WIDTH-1:0] exp_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          pend  <= 1'b0;
          exp_q <= '0;
        end else begin
          pend <= pop_ok;
          if (pop_ok) exp_q <= head;
        end
      end
      assign cmp_valid = pend;
      assign cmp_exp   = exp_q;
    end
  endgenerate

  assign mismatch = cmp_valid && (rd_data != cmp_exp);
  assign hit      = cmp_valid && (rd_data == cmp_exp);

`ifdef FIFO_CHK_FLAG_CHECK_EN
  assign flag_err = (dut_full != (level == LVL_W'(DEPTH))) || (dut_empty != (level == '0));

  always_ff @(posedge clk) begin
    if (rst) err_flag <= 1'b0;
    else     err_flag <= flag_err;
  end
`else
  logic unused_flags;
  assign unused_flags = dut_full ^ dut_empty;
  assign flag_err     = 1'b0;
  assign err_flag     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      err_order    <= 1'b0;
      err_ovf      <= 1'b0;
      err_unf      <= 1'b0;
      err_sticky   <= 1'b0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      first_exp    <= '0;
      first_act    <= '0;
      state        <= CHK_CLEAN;
    end else begin
      err_order <= mismatch;
      err_ovf   <= ovf;
      err_unf   <= unf;
      if (mismatch || ovf || unf || flag_err) err_sticky <= 1'b1;
      if (hit)      match_cnt    <= CNT_W'(sat_inc(32'(match_cnt), CNT_MAX));
      if (mismatch) mismatch_cnt <= CNT_W'(sat_inc(32'(mismatch_cnt), CNT_MAX));
      if (mismatch && (state == CHK_CLEAN)) begin
        first_exp <= cmp_exp;
        first_act <= rd_data;
        state     <= CHK_FAILED;
      end
    end
  end

endmodule

// File: tb/tb_fifo_order_checker.sv
// tb_fifo_order_checker: directed plus random stimulus against a queue-based reference model.
module tb_fifo_order_checker;

  localparam int W     = 32;
  localparam int D     = 16;
  localparam int LVL_W = $clog2(D + 1);
`ifdef FIFO_CHK_FLAG_CHECK_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [W-1:0]     wr_data;
  logic             rd_en;
  logic [W-1:0]     rd_data;
  logic             dut_full;
  logic             dut_empty;

  logic             err_order, err_ovf, err_unf, err_flag, err_sticky;
  logic [15:0]      match_cnt, mismatch_cnt;
  logic [LVL_W-1:0] level;
  logic [W-1:0]     first_exp, first_act;

  logic             s_order, s_ovf, s_unf, s_flag, s_sticky;
  logic [3:0]       s_match_cnt, s_mismatch_cnt;
  logic [LVL_W-1:0] s_level;
  logic [W-1:0]     s_first_exp, s_first_act;

  fifo_order_checker #(.WIDTH(W), .DEPTH(D), .RD_LATENCY(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .dut_full(dut_full), .dut_empty(dut_empty), .err_order(err_order), .err_ovf(err_ovf),
    .err_unf(err_unf), .err_flag(err_flag), .err_sticky(err_sticky), .match_cnt(match_cnt),
    .mismatch_cnt(mismatch_cnt), .level(level), .first_exp(first_exp), .first_act(first_act)
  );

  fifo_order_checker #(.WIDTH(W), .DEPTH(D), .RD_LATENCY(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .dut_full(dut_full), .dut_empty(dut_empty), .err_order(s_order), .err_ovf(s_ovf),
    .err_unf(s_unf), .err_flag(s_flag), .err_sticky(s_sticky), .match_cnt(s_match_cnt),
    .mismatch_cnt(s_mismatch_cnt), .level(s_level), .first_exp(s_first_exp), .first_act(s_first_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordinary queue plus the word awaiting its one-cycle-late compare.
  logic [W-1:0] mq[$];
  bit           pend;
  logic [W-1:0] pend_word;
  int           n_match, n_mis;
  bit           failed, sticky;
  logic [W-1:0] f_exp, f_act;
  bit           e_order, e_ovf, e_unf, e_flag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n, input int max_val);
    return (n > max_val) ? max_val : n;
  endfunction

  task automatic check_all();
    chk("err_order",    64'(err_order),    64'(e_order));
    chk("err_ovf",      64'(err_ovf),      64'(e_ovf));
    chk("err_unf",      64'(err_unf),      64'(e_unf));
    chk("err_flag",     64'(err_flag),     64'(e_flag));
    chk("err_sticky",   64'(err_sticky),   64'(sticky));
    chk("match_cnt",    64'(match_cnt),    64'(sat(n_match, 65535)));
    chk("mismatch_cnt", 64'(mismatch_cnt), 64'(sat(n_mis, 65535)));
    chk("level",        64'(level),        64'(mq.size()));
    chk("first_exp",    64'(first_exp),    64'(f_exp));
    chk("first_act",    64'(first_act),    64'(f_act));
    chk("sat_match",    64'(s_match_cnt),  64'(sat(n_match, 15)));
    chk("sat_mismatch", 64'(s_mismatch_cnt), 64'(sat(n_mis, 15)));
  endtask

  // mode 0: correct rd_data, 1: rd_data = rdv, 2: corrupt the pending word.
  task automatic step(input bit w, input logic [W-1:0] wd, input bit r,
                      input int mode = 0, input logic [W-1:0] rdv = '0, input bit flag_bad = 1'b0);
    bit           pop_ok, push_ok, mis;
    logic [W-1:0] popped;
    popped  = '0;
    wr_en   = w;
    wr_data = wd;
    rd_en   = r;
    if (mode == 1)     rd_data = rdv;
    else if (!pend)    rd_data = $urandom;
    else if (mode == 2) rd_data = pend_word ^ W'(32'h0000_0100);
    else               rd_data = pend_word;
    dut_full  = (mq.size() == D);
    dut_empty = (mq.size() == 0) ^ flag_bad;

    pop_ok  = r && (mq.size() > 0);
    push_ok = w && ((mq.size() < D) || pop_ok);
    e_ovf   = w && !push_ok;
    e_unf   = r && (mq.size() == 0);
    e_flag  = flag_bad && FLAG_EN;
    mis     = pend && (rd_data != pend_word);
    e_order = mis;
    if (pend && !mis) n_match++;
    if (mis) n_mis++;
    if (mis && !failed) begin
      failed = 1'b1;
      f_exp  = pend_word;
      f_act  = rd_data;
    end
    if (e_order || e_ovf || e_unf || e_flag) sticky = 1'b1;
    if (pop_ok) popped = mq.pop_front();
    if (push_ok) mq.push_back(wd);
    pend      = pop_ok;
    pend_word = popped;

    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset(input bit w, input bit r);
    rst     = 1'b1;
    wr_en   = w;
    rd_en   = r;
    wr_data = $urandom;
    rd_data = $urandom;
    mq.delete();
    pend = 1'b0; pend_word = '0;
    n_match = 0; n_mis = 0;
    failed = 1'b0; sticky = 1'b0;
    f_exp = '0; f_act = '0;
    e_order = 1'b0; e_ovf = 1'b0; e_unf = 1'b0; e_flag = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; rd_data = '0;
    dut_full = 1'b0; dut_empty = 1'b1;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);

    // In-order fill and drain.
    for (int i = 1; i <= D; i++) step(1'b1, W'(i), 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Swapped read data.
    do_reset(1'b0, 1'b0);
    step(1'b1, W'(32'hA), 1'b0);
    step(1'b1, W'(32'hB), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1, 1, W'(32'hB));
    step(1'b0, '0, 1'b0, 1, W'(32'hA));
    step(1'b0, '0, 1'b0);

    // Overflow, then full with simultaneous read.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b1, W'(100 + i), 1'b0);
    step(1'b1, W'(32'hDEAD), 1'b0);
    step(1'b1, W'(32'hBEEF), 1'b1);
    step(1'b1, W'(32'hCAFE), 1'b1);
    for (int i = 0; i < D + 1; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Read and write right at reset exit.
    do_reset(1'b1, 1'b1);
    step(1'b1, W'(32'h55), 1'b1);
    step(1'b0, '0, 1'b0);

    // Flag disagreement at level 0.
    do_reset(1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Saturation: 20 matching reads, then reset mid-stream.
    do_reset(1'b0, 1'b0);
    step(1'b1, W'(32'h1000), 1'b0);
    for (int i = 1; i <= 20; i++) step(1'b1, W'(32'h1000 + i), 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset(1'b1, 1'b1);

    // Random traffic with occasional corrupted reads and a mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      bit w, r;
      int mode;
      w    = ($urandom_range(0, 99) < 55);
      r    = ($urandom_range(0, 99) < 50);
      mode = ($urandom_range(0, 15) == 0) ? 2 : 0;
      if (i == 200) begin
        step(1'b0, '0, 1'b1);
        do_reset(1'b1, 1'b1);
      end else begin
        step(w, $urandom, r, mode);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
